// File: rtl/clkgen_pkg.sv
// ============================================================================
// clkgen_pkg
// Shared definitions for the clock-enable generator:
//   - default values for NUM_CH, ACC_W and RESET_DELAY
//   - reset sequencer state encoding (HOLD / WAIT / RUN)
// Optional build macro used by the design: CLKGEN_STATS_EN (per-channel
// 32-bit pulse counters on port ce_count).
// ============================================================================
package clkgen_pkg;

    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_ACC_W       = 16;
    localparam int DEF_RESET_DELAY = 128;

    typedef enum logic [1:0] {
        HOLD = 2'd0,    // waiting for a synchronised PLL lock
        WAIT = 2'd1,    // lock seen, counting out the reset delay
        RUN  = 2'd2     // downstream reset released, enables running
    } seq_state_t;

endpackage : clkgen_pkg

// File: rtl/clkgen_phase_acc.sv
// ============================================================================
// clkgen_phase_acc
// One clock-enable channel: phase accumulator with free-run / single-step
// control and, when CLKGEN_STATS_EN is defined, a 32-bit wrapping pulse count.
//
// Ports
//   clk         in   clock (all logic on rising edge)
//   rst         in   synchronous active-high reset
//   i_en        in   1 while the sequencer is in RUN; 0 clears acc and ce
//   i_run       in   free-run enable for this channel
//   i_step      in   single-step request (only honoured while i_run = 0)
//   i_inc       in   phase increment, ACC_W bits
//   i_hold      in   (CLKGEN_STATS_EN only) sequencer in HOLD, clears count
//   o_ce_count  out  (CLKGEN_STATS_EN only) pulses since leaving HOLD
//   o_ce        out  registered one-cycle clock-enable pulse
// ============================================================================
module clkgen_phase_acc
    import clkgen_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_run,
    input  logic             i_step,
    input  logic [ACC_W-1:0] i_inc,
`ifdef CLKGEN_STATS_EN
    input  logic             i_hold,
    output logic [31:0]      o_ce_count,
`endif
    output logic             o_ce
);

    logic [ACC_W-1:0] r_acc;
    logic             r_ce;
    logic [ACC_W:0]   w_sum;

    // The carry out of the accumulator is the enable pulse; the mean pulse
    // rate is therefore f_clk * inc / 2^ACC_W.
    assign w_sum = {1'b0, r_acc} + {1'b0, i_inc};

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_acc <= '0;
            r_ce  <= 1'b0;
        end else if (i_run) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ce  <= w_sum[ACC_W];
        end else begin
            // Stopped: phase is frozen so a later resume loses or adds no
            // pulse; each cycle of step yields exactly one pulse.
            r_ce  <= i_step;
        end
    end

    assign o_ce = r_ce;

`ifdef CLKGEN_STATS_EN
    logic [31:0] r_ce_count;

    always_ff @(posedge clk) begin
        if (rst || i_hold) begin
            r_ce_count <= '0;
        end else if (r_ce) begin
            r_ce_count <= r_ce_count + 32'd1;
        end
    end

    assign o_ce_count = r_ce_count;
`endif

endmodule : clkgen_phase_acc

// File: rtl/clock_enable_gen.sv
// ============================================================================
// clock_enable_gen
// Reset sequencer plus NUM_CH independent phase-accumulator clock enables,
// all on clk_cpu_fast.  The asynchronous PLL lock is synchronised, then the
// downstream reset is held for RESET_DELAY cycles before release; enables
// only run while the sequencer is in RUN.
// Optional build macro: CLKGEN_STATS_EN adds port ce_count.
//
// Ports
//   clk_cpu_fast  in   sole clock
//   rst           in   synchronous active-high reset
//   pll_locked    in   asynchronous PLL lock
//   run           in   [NUM_CH] per-channel free-run enable
//   step          in   [NUM_CH] per-channel single-step request
//   inc           in   [NUM_CH*ACC_W] increments, channel k at [k*ACC_W +: ACC_W]
//   ce            out  [NUM_CH] registered clock-enable pulses
//   rst_seq       out  sequenced downstream reset, active-high, registered
//   ready         out  registered, always ~rst_seq
//   ce_count      out  [NUM_CH*32] (CLKGEN_STATS_EN only) pulse counts
// ============================================================================
module clock_enable_gen
    import clkgen_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int RESET_DELAY = DEF_RESET_DELAY
) (
    input  logic                    clk_cpu_fast,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic [NUM_CH-1:0]       run,
    input  logic [NUM_CH-1:0]       step,
    input  logic [NUM_CH*ACC_W-1:0] inc,
    output logic [NUM_CH-1:0]       ce,
    output logic                    rst_seq,
    output logic                    ready
`ifdef CLKGEN_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]    ce_count
`endif
);

    localparam int CNT_W = $clog2(RESET_DELAY);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_lock_s;
    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [CNT_W-1:0] r_delay_cnt;
    logic             w_delay_done;
    logic             w_acc_en;
    logic             w_rst_seq_next;
    logic             r_rst_seq;
    logic             r_ready;

    // ---------------------------------------------------------------- sync
    always_ff @(posedge clk_cpu_fast) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lock_s     = r_sync2;
    assign w_delay_done = (r_delay_cnt == CNT_W'(RESET_DELAY - 1));

    // ------------------------------------------------------ state register
    always_ff @(posedge clk_cpu_fast) begin
        if (rst) begin
            r_state     <= HOLD;
            r_delay_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            // The count may wrap on the WAIT->RUN cycle; RUN ignores it and
            // HOLD clears it before it is used again.
            case (r_state)
                HOLD:    r_delay_cnt <= '0;
                WAIT:    r_delay_cnt <= r_delay_cnt + CNT_W'(1);
                default: r_delay_cnt <= r_delay_cnt;
            endcase
        end
    end

    // ---------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        if (!w_lock_s) begin
            w_state_next = HOLD;
        end else begin
            case (r_state)
                HOLD:    w_state_next = WAIT;
                WAIT:    if (w_delay_done) w_state_next = RUN;
                RUN:     w_state_next = RUN;
                default: w_state_next = HOLD;
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_acc_en       = 1'b0;
        w_rst_seq_next = 1'b1;
        if (r_state == RUN) begin
            w_acc_en       = 1'b1;
            w_rst_seq_next = 1'b0;
        end
    end

    always_ff @(posedge clk_cpu_fast) begin
        if (rst) begin
            r_rst_seq <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            r_rst_seq <= w_rst_seq_next;
            r_ready   <= ~w_rst_seq_next;
        end
    end

    assign rst_seq = r_rst_seq;
    assign ready   = r_ready;

`ifdef CLKGEN_STATS_EN
    logic w_hold;
    assign w_hold = (r_state == HOLD);
`endif

    // ------------------------------------------------------------ channels
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            clkgen_phase_acc #(
                .ACC_W (ACC_W)
            ) u_acc (
                .clk        (clk_cpu_fast),
                .rst        (rst),
                .i_en       (w_acc_en),
                .i_run      (run[gi]),
                .i_step     (step[gi]),
                .i_inc      (inc[gi*ACC_W +: ACC_W]),
`ifdef CLKGEN_STATS_EN
                .i_hold     (w_hold),
                .o_ce_count (ce_count[gi*32 +: 32]),
`endif
                .o_ce       (ce[gi])
            );
        end
    endgenerate

endmodule : clock_enable_gen

// File: doc/clock_enable_gen.md
CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent clock-enable channels (1..8).
REQ-002 Parameter ACC_W, default 16, phase-accumulator width per channel (8..24).
REQ-003 Parameter RESET_DELAY, default 128, cycles from synchronised lock to reset release (>=2).
REQ-004 clk_cpu_fast  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 pll_locked  in  1  asynchronous PLL lock, synchronised internally.
REQ-007 run  in  NUM_CH  per-channel free-run enable.
REQ-008 step  in  NUM_CH  per-channel single-step request, sampled each cycle.
REQ-009 inc  in  NUM_CH*ACC_W  phase increment; channel k at bits [k*ACC_W +: ACC_W].
REQ-010 ce  out  NUM_CH  registered one-cycle clock-enable pulses.
REQ-011 rst_seq  out  1  sequenced downstream reset, active-high, registered.
REQ-012 ready  out  1  registered, equals ~rst_seq.

Function
REQ-013 pll_locked SHALL pass a 2-flop synchroniser; lock_s = second stage.
REQ-014 Sequencer states HOLD, WAIT, RUN; HOLD->WAIT when lock_s=1; WAIT->RUN when delay counter = RESET_DELAY-1; any state->HOLD when lock_s=0.
REQ-015 Delay counter SHALL clear in HOLD, increment by 1 in WAIT, hold in RUN; width = clog2(RESET_DELAY).
REQ-016 rst_seq SHALL be 1 in HOLD and WAIT, 0 in RUN, updated one cycle after the state register.
REQ-017 Outside RUN every accumulator SHALL clear to 0 and every ce SHALL be 0.
REQ-018 In RUN with run[k]=1: sum = {1'b0,acc}+{1'b0,inc_k} (ACC_W+1 bits); acc <= sum[ACC_W-1:0]; ce[k] <= sum[ACC_W].
REQ-019 Mean enable rate SHALL be f_clk*inc_k/2^ACC_W; inc_k=0 SHALL yield no pulses.
REQ-020 In RUN with run[k]=0: acc SHALL hold; step[k]=1 SHALL give ce[k]=1 next cycle, acc unchanged; step[k] held N cycles gives N pulses.
REQ-021 step[k] SHALL be ignored while run[k]=1.
REQ-022 run[k] 1->0 freezes acc at its current value; 0->1 resumes accumulation from that value, no pulse lost or added.
REQ-023 inc change SHALL take effect on the next accumulation cycle; no glitch pulse.
REQ-024 Lock loss mid-RUN: within 3 cycles ce all 0, rst_seq 1, accumulators 0.
REQ-025 Channels SHALL be mutually independent; simultaneous pulses on all channels permitted.

Reset
REQ-026 rst=1 SHALL set synchroniser 0, state HOLD, delay counter 0, accumulators 0, ce 0, rst_seq 1, ready 0, stats counters 0.
REQ-027 rst dominates every other input in the same cycle.

Configuration
REQ-028 Macro CLKGEN_STATS_EN: when defined, output ce_count (NUM_CH*32) SHALL give per-channel 32-bit wrapping count of ce pulses since leaving HOLD, cleared in HOLD.
REQ-029 Without CLKGEN_STATS_EN the port and counters SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package clkgen_pkg SHALL hold the sequencer state enum (HOLD/WAIT/RUN) and default values of NUM_CH, ACC_W, RESET_DELAY.
REQ-031 Per-channel accumulator, run/step logic and optional stats counter SHALL be sub-module clkgen_phase_acc, instantiated NUM_CH times by generate.

Verification
REQ-032 pll_locked 0->1, RESET_DELAY=128 -> rst_seq falls exactly 2+128+1 cycles after edge (+/-1 for async sample); ce 0 until then.
REQ-033 ACC_W=16, inc=16384, run=1 -> ce pulses every 4th cycle; inc=32768 -> every 2nd cycle.
REQ-034 inc=2300, run=1 for 65536 cycles -> exactly 2300 pulses (~1.79 MHz at 51 MHz).
REQ-035 run=0, step pulsed 3 single cycles -> exactly 3 ce pulses, acc unchanged; step while run=1 -> no extra pulses.
REQ-036 pll_locked dropped in RUN with inc=16384 -> ce 0 and rst_seq 1 within 3 cycles; relock -> full RESET_DELAY repeated.
REQ-037 With CLKGEN_STATS_EN, inc=16384 for 400 RUN cycles -> ce_count=100; rst mid-count -> 0 next cycle.
